// File: rtl/usb_out_ep_stream.sv
// usb_out_ep_stream: drains one OUT endpoint of the protocol engine into a tagged byte stream.
// Latency: 2 cycles from engine get to strm_valid (1-cycle engine read + FIFO write).
// Backpressure: gets are credited against FIFO space, so strm_ready=0 stalls the engine, never drops.
// Optional: define USB_OUT_EP_PKT_LEN_EN to enable the pkt_done/pkt_len packet length reporting.
module usb_out_ep_stream #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       out_ep_data_avail,
  input  logic       out_ep_setup,
  output logic       out_ep_data_get,
  input  logic [7:0] out_ep_data,
  input  logic       flush,
  output logic       strm_valid,
  input  logic       strm_ready,
  output logic [7:0] strm_data,
  output logic       strm_sop,
  output logic       strm_eop,
  output logic       strm_setup,
  output logic       pkt_done,
  output logic [6:0] pkt_len
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic          inflight_q;
  logic          sop_pend_q, sop_pend_d;
  logic          setup_q, setup_d;
  logic [10:0]   mem_q [FIFO_DEPTH];

  logic          get_c;
  logic          push_c;
  logic          pop_c;
  logic          credit_c;
  logic          cap_eop_c;
  logic [10:0]   head_c;

  // Credit counts both stored bytes and the byte still coming back from the engine.
  assign credit_c  = (({1'b0, count_q} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(FIFO_DEPTH));
  // The engine lowers avail right after handing out its last byte.
  assign cap_eop_c = !out_ep_data_avail;

  // Next-state, get strobe and FIFO write decision.
  always_comb begin
    state_d    = state_q;
    get_c      = 1'b0;
    push_c     = 1'b0;
    sop_pend_d = sop_pend_q;
    setup_d    = setup_q;
    if (flush) begin
      // Flush drops whatever is in flight and issues no get this cycle.
      state_d    = DISCARD;
      sop_pend_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (out_ep_data_avail && credit_c) begin
            get_c      = 1'b1;
            state_d    = DRAIN;
            sop_pend_d = 1'b1;
            setup_d    = out_ep_setup;
          end
        end
        DRAIN: begin
          get_c = out_ep_data_avail && credit_c;
          if (inflight_q) begin
            push_c     = 1'b1;
            sop_pend_d = 1'b0;
            if (cap_eop_c) begin
              state_d = IDLE;
            end
          end
        end
        DISCARD: begin
          get_c = out_ep_data_avail;
          if (!out_ep_data_avail && !inflight_q) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Occupancy update; flush overrides any push or pop.
  always_comb begin
    pop_c   = (count_q != '0) && strm_ready && !flush;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Keep get low while in reset so the engine is not advanced.
  assign out_ep_data_get = get_c & reset_n;

  // Control state, pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
      sop_pend_q <= 1'b0;
      setup_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      inflight_q <= get_c;
      sop_pend_q <= sop_pend_d;
      setup_q    <= setup_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // FIFO storage: {setup, eop, sop, data}.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {setup_q, cap_eop_c, sop_pend_q, out_ep_data};
    end
  end

  // Head fields are forced to zero when empty so reset leaves every output low.
  assign head_c     = mem_q[rd_ptr_q];
  assign strm_valid = (count_q != '0);
  assign strm_data  = strm_valid ? head_c[7:0] : 8'h00;
  assign strm_sop   = strm_valid & head_c[8];
  assign strm_eop   = strm_valid & head_c[9];
  assign strm_setup = strm_valid & head_c[10];

`ifdef USB_OUT_EP_PKT_LEN_EN
  logic [6:0] len_cnt_q;
  logic [6:0] len_next_c;
  logic [6:0] pkt_len_q;
  logic       pkt_done_q;

  assign len_next_c = sop_pend_q ? 7'd1 : (len_cnt_q + 7'd1);

  // Count captured bytes; publish the total when the eop byte is written.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_cnt_q  <= 7'd0;
      pkt_len_q  <= 7'd0;
      pkt_done_q <= 1'b0;
    end else begin
      pkt_done_q <= 1'b0;
      if (flush) begin
        len_cnt_q <= 7'd0;
      end else if (push_c) begin
        len_cnt_q <= len_next_c;
        if (cap_eop_c) begin
          pkt_len_q  <= len_next_c;
          pkt_done_q <= 1'b1;
        end
      end
    end
  end

  assign pkt_done = pkt_done_q;
  assign pkt_len  = pkt_len_q;
`else
  assign pkt_done = 1'b0;
  assign pkt_len  = 7'd0;
`endif

endmodule

// File: tb/tb_usb_out_ep_stream.sv
// Directed bench for usb_out_ep_stream with a behavioural OUT engine and a byte scoreboard.
module tb_usb_out_ep_stream;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       out_ep_data_avail;
  logic       out_ep_setup;
  logic       out_ep_data_get;
  logic [7:0] out_ep_data = 8'h00;
  logic       flush;
  logic       strm_valid;
  logic       strm_ready;
  logic [7:0] strm_data;
  logic       strm_sop;
  logic       strm_eop;
  logic       strm_setup;
  logic       pkt_done;
  logic [6:0] pkt_len;

  always #5 clk = ~clk;

  usb_out_ep_stream #(.FIFO_DEPTH(DEPTH)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .out_ep_data_avail (out_ep_data_avail),
    .out_ep_setup      (out_ep_setup),
    .out_ep_data_get   (out_ep_data_get),
    .out_ep_data       (out_ep_data),
    .flush             (flush),
    .strm_valid        (strm_valid),
    .strm_ready        (strm_ready),
    .strm_data         (strm_data),
    .strm_sop          (strm_sop),
    .strm_eop          (strm_eop),
    .strm_setup        (strm_setup),
    .pkt_done          (pkt_done),
    .pkt_len           (pkt_len)
  );

  // Engine model: bytes appended to eng_mem, one byte returned the cycle after each get.
  logic [7:0] eng_mem [256];
  int         eng_len = 0;
  int         eng_idx = 0;
  assign out_ep_data_avail = (eng_idx < eng_len);

  always @(posedge clk) begin
    if (out_ep_data_get) begin
      out_ep_data <= eng_mem[eng_idx[7:0]];
      eng_idx     <= eng_idx + 1;
    end
  end

  int         total = 0;
  int         bad = 0;
  int         gets_total = 0;
  int         done_cnt = 0;
  logic [6:0] last_len = 7'd0;
  logic [10:0] exp_q [$];
  logic [7:0] pbuf [16];

  always @(posedge clk) begin
    if (out_ep_data_get) gets_total = gets_total + 1;
    if (pkt_done) begin
      done_cnt = done_cnt + 1;
      last_len = pkt_len;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total = total + 1;
    assert (obs === expv) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Append n bytes of pbuf to the engine; expect bytes from exp_from onward as one packet.
  task automatic load_pkt(input int n, input logic setup, input int exp_from);
    for (int i = 0; i < n; i++) begin
      eng_mem[(eng_len + i) % 256] = pbuf[i];
      if (i >= exp_from) exp_q.push_back({setup, (i == n - 1), (i == exp_from), pbuf[i]});
    end
    out_ep_setup = setup;
    eng_len = eng_len + n;
  endtask

  task automatic wait_drain(input string tag);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_ep_data_avail) break;
    end
    repeat (3) @(negedge clk);
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic check_len(input string tag, input int exp_len, input int exp_done);
`ifdef USB_OUT_EP_PKT_LEN_EN
    chk({tag, "_len"}, last_len, exp_len);
    chk({tag, "_done"}, done_cnt, exp_done);
`else
    chk({tag, "_len_tied"}, pkt_len, 0);
    chk({tag, "_done_tied"}, done_cnt, 0);
`endif
  endtask

  // Scoreboard: compare every accepted head against the next expected entry.
  always @(negedge clk) begin
    #2;
    if (reset_n && strm_valid && strm_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_byte", exp_q.size(), 1);
      end else begin
        chk("stream_entry", {strm_setup, strm_eop, strm_sop, strm_data}, exp_q.pop_front());
      end
    end
  end

  initial begin
    int g;
    int first;
    int last;
    int g0;
    int d0;

    reset_n    = 1'b0;
    flush      = 1'b0;
    strm_ready = 1'b1;
    out_ep_setup = 1'b0;

    // Packet 1 is pending during reset: nothing may move.
    for (int i = 0; i < 8; i++) pbuf[i] = 8'h10 + 8'(i);
    load_pkt(8, 1'b0, 0);
    #1;
    chk("rst_get", out_ep_data_get, 0);
    chk("rst_valid", strm_valid, 0);
    chk("rst_data", strm_data, 0);
    chk("rst_tags", {strm_sop, strm_eop, strm_setup}, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_len", pkt_len, 0);
    repeat (2) @(negedge clk);

    // 8-byte OUT packet with consumer always ready: 8 back-to-back gets.
    reset_n = 1'b1;
    g = 0; first = -1; last = -1;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (out_ep_data_get) begin
        g = g + 1;
        if (first < 0) first = i;
        last = i;
      end
      @(negedge clk);
    end
    chk("p1_gets", g, 8);
    chk("p1_consecutive", last - first, 7);
    wait_drain("p1_drain");
    check_len("p1", 8, 1);

    // SETUP packet: every byte tagged setup.
    d0 = done_cnt;
    pbuf[0] = 8'h80; pbuf[1] = 8'h06; pbuf[2] = 8'h00; pbuf[3] = 8'h01;
    pbuf[4] = 8'h00; pbuf[5] = 8'h00; pbuf[6] = 8'h40; pbuf[7] = 8'h00;
    load_pkt(8, 1'b1, 0);
    wait_drain("setup_drain");
    check_len("setup", 8, d0 + 1);
    out_ep_setup = 1'b0;

    // Consumer stalled: exactly DEPTH gets, head held stable, then drain.
    d0 = done_cnt;
    g0 = gets_total;
    strm_ready = 1'b0;
    for (int i = 0; i < 8; i++) pbuf[i] = 8'h30 + 8'(i);
    load_pkt(8, 1'b0, 0);
    g = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_ep_data_get) g = g + 1;
      @(negedge clk);
    end
    #1;
    chk("stall_gets", g, DEPTH);
    chk("stall_get_low", out_ep_data_get, 0);
    chk("stall_head", {strm_valid, strm_sop, strm_eop, strm_data}, {3'b110, 8'h30});
    @(negedge clk);
    #1;
    chk("stall_head_hold", {strm_valid, strm_sop, strm_data}, {2'b11, 8'h30});
    strm_ready = 1'b1;
    wait_drain("stall_drain");
    chk("stall_total_gets", gets_total - g0, 8);
    check_len("stall", 8, d0 + 1);

    // Single-byte packet, followed two cycles later by another packet.
    d0 = done_cnt;
    g0 = gets_total;
    @(negedge clk);
    pbuf[0] = 8'hA5;
    load_pkt(1, 1'b0, 0);
    #1;
    chk("one_get", out_ep_data_get, 1);
    @(negedge clk);
    #1;
    chk("one_capture_noget", out_ep_data_get, 0);
    @(negedge clk);
    pbuf[0] = 8'h5A; pbuf[1] = 8'h5B;
    load_pkt(2, 1'b0, 0);
    #1;
    chk("one_next_get", out_ep_data_get, 1);
    wait_drain("one_drain");
    chk("one_total_gets", gets_total - g0, 3);
    check_len("one", 2, d0 + 2);

    // Flush after 3 of 10 bytes: everything of that packet is discarded.
    d0 = done_cnt;
    g0 = gets_total;
    strm_ready = 1'b0;
    for (int i = 0; i < 10; i++) pbuf[i] = 8'h60 + 8'(i);
    load_pkt(10, 1'b0, 10);
    g = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_ep_data_get) g = g + 1;
      if (g == 3) break;
      @(negedge clk);
    end
    chk("fl_pre_gets", g, 3);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_cycle_noget", out_ep_data_get, 0);
    @(negedge clk);
    flush = 1'b0;
    strm_ready = 1'b1;
    #1;
    chk("fl_valid_low", strm_valid, 0);
    g = 0;
    for (int i = 0; i < 14; i++) begin
      if (out_ep_data_get) g = g + 1;
      @(negedge clk);
      #1;
    end
    chk("fl_discard_gets", g, 7);
    wait_drain("fl_drain");
    chk("fl_total_gets", gets_total - g0, 10);
    chk("fl_no_done", done_cnt, d0);
    for (int i = 0; i < 3; i++) pbuf[i] = 8'h70 + 8'(i);
    load_pkt(3, 1'b0, 0);
    wait_drain("fl_next_drain");
    check_len("fl_next", 3, d0 + 1);

    // Reset mid-packet: outputs drop at once, the rest drains as a new packet.
    d0 = done_cnt;
    strm_ready = 1'b0;
    for (int i = 0; i < 6; i++) pbuf[i] = 8'h90 + 8'(i);
    load_pkt(6, 1'b1, 2);
    g = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (out_ep_data_get) g = g + 1;
      if (g == 2) break;
      @(negedge clk);
    end
    @(negedge clk);
    #1;
    chk("mr_valid_before", strm_valid, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_get", out_ep_data_get, 0);
    chk("mr_valid", strm_valid, 0);
    chk("mr_data", strm_data, 0);
    chk("mr_tags", {strm_sop, strm_eop, strm_setup}, 0);
    chk("mr_len", {pkt_done, pkt_len}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    strm_ready = 1'b1;
    wait_drain("mr_drain");
    check_len("mr", 4, d0 + 1);
    out_ep_setup = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
